// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths and the queue entry type for the instruction
// prefetch queue (fetch_queue / fetch_fifo).
//   XLEN        address width
//   ILEN        instruction width
//   INSTR_BYTES sequential fetch stride
//   fetch_entry_t {pc, instr} as stored in the queue
package fetch_pkg;
   localparam int XLEN        = 64;
   localparam int ILEN        = 32;
   localparam int INSTR_BYTES = 4;
   localparam int ENTRY_W     = XLEN + ILEN;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of fetch entries.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   clear_i       drop all entries (wins over push/pop)
//   push_i        write push_data_i at tail (ignored when full)
//   pop_i         advance head (ignored when empty)
//   head_o        head entry (storage is zeroed at reset)
//   count_o       number of valid entries
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear_i,
   input  logic                   push_i,
   input  logic [ENTRY_W-1:0]     push_data_i,
   input  logic                   pop_i,
   output logic [ENTRY_W-1:0]     head_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic               do_push, do_pop;

   always_comb begin
      do_push  = push_i && (count_q != CW'(DEPTH));
      do_pop   = pop_i && (count_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is reset so the head reads as zero straight out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (do_push && !clear_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue between instruction memory and IF/ID.
// Issues sequential word-aligned fetches under a credit limit, buffers the
// returned words with their PCs, and flushes on a taken-branch redirect.
// Optional build macro: FETCH_QUEUE_BYPASS_EN -- a response arriving at an
// empty queue drives the outputs in the same cycle.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req_valid/req_addr       fetch request to memory, req_ready accepts it
//   resp_valid/resp_instr    in-order response, one per accepted request
//   out_valid/out_instr/out_pc  head instruction to IF/ID, out_ready pops it
//   redirect/redirect_pc     flush and refetch from the branch target
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        rst,
   output logic        req_valid,
   output logic [63:0] req_addr,
   input  logic        req_ready,
   input  logic        resp_valid,
   input  logic [31:0] resp_instr,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [63:0] out_pc,
   input  logic        out_ready,
   input  logic        redirect,
   input  logic [63:0] redirect_pc
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int DW = $clog2(2 * DEPTH) + 1;
   localparam logic [XLEN-1:0] STRIDE = XLEN'(INSTR_BYTES);

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] resp_pc_q, resp_pc_d;
   logic [CW-1:0]   live_q, live_d;
   logic [DW-1:0]   drop_q, drop_d;

   logic [CW-1:0]   count;
   logic [CW:0]     credit_used;
   fetch_entry_t    head_e, push_e;
   logic            req_fire, resp_drop, resp_live, bypass, push, pop;

   always_comb begin
      // Entries held plus responses still owed must leave room for one more.
      credit_used = {1'b0, count} + {1'b0, live_q};
      req_valid   = rst && !redirect && (credit_used < (CW+1)'(DEPTH));
      req_addr    = fetch_pc_q;
      req_fire    = req_valid && req_ready;

      // A response with nothing owed (live = drop = 0) matches neither term.
      resp_drop = resp_valid && (drop_q != '0);
      resp_live = resp_valid && (drop_q == '0) && (live_q != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
      bypass = resp_live && (count == '0) && !redirect;
`else
      bypass = 1'b0;
`endif

      out_valid = !redirect && ((count != '0) || bypass);
      out_instr = bypass ? resp_instr : head_e.instr;
      out_pc    = bypass ? resp_pc_q  : head_e.pc;

      pop          = out_valid && out_ready && (count != '0);
      push         = resp_live && !redirect && !(bypass && out_ready);
      push_e.pc    = resp_pc_q;
      push_e.instr = resp_instr;

      if (redirect) begin
         fetch_pc_d = redirect_pc;
         resp_pc_d  = redirect_pc;
         live_d     = '0;
         // Everything still owed becomes junk, less the one arriving now.
         drop_d     = drop_q + DW'(live_q) - DW'(resp_drop || resp_live);
      end else begin
         fetch_pc_d = req_fire  ? fetch_pc_q + STRIDE : fetch_pc_q;
         resp_pc_d  = resp_live ? resp_pc_q + STRIDE  : resp_pc_q;
         live_d     = live_q + CW'(req_fire) - CW'(resp_live);
         drop_d     = drop_q - DW'(resp_drop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         live_q     <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         live_q     <= live_d;
         drop_q     <= drop_d;
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (redirect),
      .push_i      (push),
      .push_data_i (push_e),
      .pop_i       (pop),
      .head_o      (head_e),
      .count_o     (count)
   );
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order memory model with configurable latency and
// a queue-level reference of buffered PCs and outstanding requests.
module tb_fetch_queue;
   localparam int          DEPTH    = 4;
   localparam logic [63:0] RESET_PC = 64'h0;
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam int BYP_LAT = 0;
`else
   localparam int BYP_LAT = 1;
`endif

   logic        clk = 1'b0, rst = 1'b0;
   logic        req_valid, req_ready = 1'b0;
   logic [63:0] req_addr;
   logic        resp_valid = 1'b0;
   logic [31:0] resp_instr = '0;
   logic        out_valid, out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [63:0] out_pc;
   logic        redirect = 1'b0;
   logic [63:0] redirect_pc = '0;

   always #5 clk = ~clk;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_instr(resp_instr),
      .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
      .out_ready(out_ready), .redirect(redirect), .redirect_pc(redirect_pc)
   );

   typedef struct {
      logic [63:0] addr;
      bit          stale;
      int          due;
   } mreq_t;

   mreq_t       infl[$];     // requests accepted by memory, oldest first
   logic [63:0] pend_q[$];   // PCs of instructions buffered, not yet consumed
   logic [63:0] exp_fetch;
   int          cyc, vecs, miss, pops, lat_min, lat_max;
   bit          e_req_valid, e_out_valid, e_byp, r_have;
   logic [63:0] e_out_pc;
   mreq_t       r;

   function automatic logic [31:0] mem_word(logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
   endfunction

   function automatic int live_cnt();
      int n = 0;
      foreach (infl[i]) if (!infl[i].stale) n++;
      return n;
   endfunction

   // Apply one cycle of inputs and derive what the outputs must be.
   task automatic drive(bit rdr, logic [63:0] rpc, bit rr, bit ordy);
      @(negedge clk);
      redirect = rdr; redirect_pc = rpc; req_ready = rr; out_ready = ordy;
      r_have = (infl.size() != 0) && (infl[0].due <= cyc);
      if (r_have) r = infl[0];
      resp_valid = r_have;
      resp_instr = r_have ? mem_word(r.addr) : $urandom();
      assert (!resp_valid || infl.size() != 0);
      e_req_valid = !rdr && ((pend_q.size() + live_cnt()) < DEPTH);
`ifdef FETCH_QUEUE_BYPASS_EN
      e_byp = r_have && !r.stale && (pend_q.size() == 0) && !rdr;
`else
      e_byp = 1'b0;
`endif
      e_out_valid = !rdr && ((pend_q.size() != 0) || e_byp);
      e_out_pc    = e_byp ? r.addr : ((pend_q.size() != 0) ? pend_q[0] : 64'h0);
      #1;
   endtask

   // Advance the reference across the coming clock edge.
   task automatic commit();
      int due;
      if (r_have) infl.delete(0);
      if (redirect) begin
         pend_q.delete();
         foreach (infl[i]) infl[i].stale = 1'b1;
         exp_fetch = redirect_pc;
      end else begin
         if (e_out_valid && out_ready) begin
            pops++;
            if (!e_byp) pend_q.delete(0);
         end
         if (r_have && !r.stale && !(e_byp && out_ready)) pend_q.push_back(r.addr);
         if (e_req_valid && req_ready) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (infl.size() != 0 && infl[infl.size()-1].due >= due)
               due = infl[infl.size()-1].due + 1;
            infl.push_back('{exp_fetch, 1'b0, due});
            exp_fetch += 64'd4;
         end
      end
      cyc++;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      vecs++;
      if (req_valid !== 1'b0 || out_valid !== 1'b0) begin
         miss++; $display("FAIL reset.valid got req=%0b out=%0b want 0/0", req_valid, out_valid);
      end
      vecs++;
      if (out_instr !== 32'h0 || out_pc !== 64'h0) begin
         miss++; $display("FAIL reset.data got instr=%h pc=%h want 0/0", out_instr, out_pc);
      end
      rst = 1'b1;
      #1;
      vecs++;
      if (req_valid !== 1'b1 || req_addr !== RESET_PC) begin
         miss++; $display("FAIL reset.first_req got %0b/%h want 1/%h", req_valid, req_addr, RESET_PC);
      end
      exp_fetch = RESET_PC;
   endtask

   task automatic test_stream();
      int p0;
      lat_min = 1; lat_max = 1;
      for (int i = 0; i < 30; i++) begin
         if (i == 10) p0 = pops;
         drive(1'b0, {$urandom(), $urandom()}, 1'b1, 1'b1);
         vecs++;
         if (req_valid !== e_req_valid || (e_req_valid && req_addr !== exp_fetch)) begin
            miss++; $display("FAIL stream.req cyc=%0d got %0b/%h want %0b/%h", cyc, req_valid, req_addr, e_req_valid, exp_fetch);
         end
         vecs++;
         if (out_valid !== e_out_valid || (e_out_valid && (out_pc !== e_out_pc || out_instr !== mem_word(e_out_pc)))) begin
            miss++; $display("FAIL stream.out cyc=%0d got %0b/%h/%h want %0b/%h/%h", cyc, out_valid, out_pc, out_instr, e_out_valid, e_out_pc, mem_word(e_out_pc));
         end
         commit();
      end
      vecs++;
      if (pops - p0 != 20) begin
         miss++; $display("FAIL stream.rate got %0d pops in 20 cycles want 20", pops - p0);
      end
   endtask

   task automatic test_stall();
      lat_min = 1; lat_max = 1;
      for (int i = 0; i < 24; i++) begin
         drive(1'b0, {$urandom(), $urandom()}, 1'b1, !(i >= 4 && i < 14));
         vecs++;
         if (req_valid !== e_req_valid || (e_req_valid && req_addr !== exp_fetch)) begin
            miss++; $display("FAIL stall.req cyc=%0d got %0b/%h want %0b/%h", cyc, req_valid, req_addr, e_req_valid, exp_fetch);
         end
         vecs++;
         if (out_valid !== e_out_valid || (e_out_valid && (out_pc !== e_out_pc || out_instr !== mem_word(e_out_pc)))) begin
            miss++; $display("FAIL stall.out cyc=%0d got %0b/%h/%h want %0b/%h/%h", cyc, out_valid, out_pc, out_instr, e_out_valid, e_out_pc, mem_word(e_out_pc));
         end
         if (i == 13) begin
            vecs++;
            if (req_valid !== 1'b0) begin
               miss++; $display("FAIL stall.credit got req_valid=%0b want 0", req_valid);
            end
         end
         commit();
      end
   endtask

   // Latency 3 keeps several requests in flight when the redirect lands.
   task automatic test_redirect(int lat, logic [63:0] tgt, string nm);
      int rc = -1, resp_c = -1, ov_c = -1;
      logic [63:0] first_pc = '1;
      lat_min = lat; lat_max = lat;
      for (int i = 0; i < 24; i++) begin
         drive(i == 8, tgt, 1'b1, 1'b1);
         if (i == 8) rc = cyc;
         if (rc >= 0 && cyc > rc && r_have && !r.stale && resp_c < 0) resp_c = cyc;
         if (rc >= 0 && cyc > rc && out_valid === 1'b1 && ov_c < 0) begin
            ov_c = cyc; first_pc = out_pc;
         end
         vecs++;
         if (req_valid !== e_req_valid || (e_req_valid && req_addr !== exp_fetch)) begin
            miss++; $display("FAIL %s.req cyc=%0d got %0b/%h want %0b/%h", nm, cyc, req_valid, req_addr, e_req_valid, exp_fetch);
         end
         vecs++;
         if (out_valid !== e_out_valid || (e_out_valid && (out_pc !== e_out_pc || out_instr !== mem_word(e_out_pc)))) begin
            miss++; $display("FAIL %s.out cyc=%0d got %0b/%h/%h want %0b/%h/%h", nm, cyc, out_valid, out_pc, out_instr, e_out_valid, e_out_pc, mem_word(e_out_pc));
         end
         commit();
      end
      vecs++;
      if (first_pc !== tgt) begin
         miss++; $display("FAIL %s.first_pc got %h want %h", nm, first_pc, tgt);
      end
      vecs++;
      if (resp_c < 0 || ov_c - resp_c != BYP_LAT) begin
         miss++; $display("FAIL %s.latency got %0d want %0d", nm, ov_c - resp_c, BYP_LAT);
      end
   endtask

   task automatic test_random();
      logic [63:0] t;
      lat_min = 1; lat_max = 4;
      for (int i = 0; i < 600; i++) begin
         t = {$urandom(), $urandom()};
         if ($urandom_range(3, 0) == 0) t = 64'hFFFF_FFFF_FFFF_FFF0;
         t[1:0] = 2'b00;
         drive($urandom_range(99, 0) < 3, t, $urandom_range(3, 0) != 0, $urandom_range(9, 0) < 7);
         vecs++;
         if (req_valid !== e_req_valid || (e_req_valid && req_addr !== exp_fetch)) begin
            miss++; $display("FAIL random.req cyc=%0d got %0b/%h want %0b/%h", cyc, req_valid, req_addr, e_req_valid, exp_fetch);
         end
         vecs++;
         if (out_valid !== e_out_valid || (e_out_valid && (out_pc !== e_out_pc || out_instr !== mem_word(e_out_pc)))) begin
            miss++; $display("FAIL random.out cyc=%0d got %0b/%h/%h want %0b/%h/%h", cyc, out_valid, out_pc, out_instr, e_out_valid, e_out_pc, mem_word(e_out_pc));
         end
         commit();
      end
   endtask

   task automatic test_midreset();
      lat_min = 2; lat_max = 2;
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, '0, 1'b1, 1'b1);
         commit();
      end
      @(negedge clk);
      rst = 1'b0; redirect = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; out_ready = 1'b0;
      #1;
      vecs++;
      if (out_valid !== 1'b0 || req_valid !== 1'b0) begin
         miss++; $display("FAIL midreset.async got out=%0b req=%0b want 0/0", out_valid, req_valid);
      end
      infl.delete(); pend_q.delete(); exp_fetch = RESET_PC;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      vecs++;
      if (req_valid !== 1'b1 || req_addr !== RESET_PC || out_valid !== 1'b0) begin
         miss++; $display("FAIL midreset.release got %0b/%h out=%0b want 1/%h out=0", req_valid, req_addr, out_valid, RESET_PC);
      end
      lat_min = 1; lat_max = 3;
      for (int i = 0; i < 15; i++) begin
         drive(1'b0, '0, 1'b1, 1'b1);
         vecs++;
         if (out_valid !== e_out_valid || (e_out_valid && (out_pc !== e_out_pc || out_instr !== mem_word(e_out_pc)))) begin
            miss++; $display("FAIL midreset.out cyc=%0d got %0b/%h/%h want %0b/%h/%h", cyc, out_valid, out_pc, out_instr, e_out_valid, e_out_pc, mem_word(e_out_pc));
         end
         commit();
      end
   endtask

   initial begin
      vecs = 0; miss = 0; pops = 0; cyc = 0;
      test_reset();
      test_stream();
      test_stall();
      test_redirect(3, 64'h100, "redirect_lat3");
      test_redirect(1, 64'h2000, "redirect_collide");
      test_redirect(2, 64'hFFFF_FFFF_FFFF_FFF8, "redirect_wrap");
      test_random();
      test_midreset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue between the instruction memory and the IF/ID pipeline register. Generates sequential fetch addresses, issues them to a pipelined instruction memory under a credit limit, and buffers returned instructions with their PCs. Presents one instruction per cycle to IF/ID, holds it while the hazard unit stalls, and discards everything on a taken-branch redirect from ID.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 64'h0: first fetch address after reset.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  out  1  fetch request valid.
- req_addr  out  64  byte address of requested instruction, word-aligned.
- req_ready  in  1  memory accepts request this cycle.
- resp_valid  in  1  instruction returned this cycle; in order, one per accepted request, ≥1 cycle after acceptance.
- resp_instr  in  32  returned instruction word.
- out_valid  out  1  out_instr/out_pc valid.
- out_instr  out  32  instruction to IF/ID.
- out_pc  out  64  PC of out_instr.
- out_ready  in  1  IF/ID consumes (low during load-use stall).
- redirect  in  1  taken branch in ID; flush and refetch.
- redirect_pc  in  64  branch target.

## Operation
- Registers: fetch_pc (next request), resp_pc (PC of next live response), queue count, live (outstanding responses to keep), drop (outstanding responses to discard).
- Request issue: req_valid = !redirect && (count + live) < DEPTH; req_addr = fetch_pc. On req_valid && req_ready: fetch_pc += 4, live += 1.
- Response: if drop != 0, drop -= 1, data discarded. Otherwise live -= 1, entry {resp_pc, resp_instr} pushed, resp_pc += 4. Credit rule guarantees no push into a full queue.
- Output: head entry; out_valid = count != 0 && !redirect. Pop on out_valid && out_ready.
- Redirect (highest priority): queue cleared; fetch_pc and resp_pc ← redirect_pc; drop ← drop + live − (1 if a response arrives this cycle, consumed by the drop/live update above); live ← 0; no request issued, no pop.
- Push and pop in same cycle: count unchanged, both pointers advance.
- Address arithmetic modulo 2^64; wrap at 64'hFFFF_FFFF_FFFF_FFFC → 0 permitted silently.
- resp_valid with live = drop = 0 is a protocol error; response ignored; assertion in bench.

## Timing
- Reset values: req_valid 0 during reset then 1 (fetch_pc = RESET_PC); out_valid 0; out_instr 0; out_pc 0; count/live/drop 0.
- First request the first cycle after rst deasserts.
- Response → out_valid: next cycle (queue registered), unless bypass enabled.
- Steady state with 1-cycle memory and out_ready=1: one instruction per cycle.
- Redirect at cycle N: req_valid low at N, req_addr = redirect_pc at N+1, out_valid low at N and until the first target response is queued.
- Reset asserted mid-operation: all state cleared asynchronously; in-flight memory responses after reset release are the memory's responsibility (memory is reset by the same rst).
- Counter widths: count and live $clog2(DEPTH)+1 bits; drop $clog2(2·DEPTH)+1 bits.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: when count = 0, drop = 0, resp_valid=1 and no redirect, the response drives out_valid/out_instr/out_pc combinationally that cycle; if out_ready=1 it is not pushed. Zero-cycle response-to-output latency.
- Undefined: all outputs from registered queue state only; one-cycle latency.

## Structure
- Package fetch_pkg: XLEN=64, ILEN=32, INSTR_BYTES=4, fetch_entry_t struct {pc, instr}.
- Sub-module fetch_fifo: DEPTH-entry synchronous FIFO of fetch_entry_t with push, pop, clear, count; fetch_queue holds PC and credit logic.

## Test plan
- Reset release, memory 1-cycle, out_ready=1 → req_addr 0,4,8,…; out_pc 0,4,8 one per cycle from cycle 2; out_instr matches memory words.
- out_ready=0 for 10 cycles → requests stop after count+live = 4; out_pc held at stalled value; resume with no loss or duplicate.
- Memory latency 3, four requests in flight, redirect to 0x100 → next req_addr 0x100; next three-plus old responses discarded; first out_pc 0x100.
- Redirect in the same cycle as resp_valid and out_valid&&out_ready → no pop counted, response dropped, drop = live−1.
- FETCH_QUEUE_BYPASS_EN, empty queue, response at cycle N → out_valid at N with that instruction; without macro → at N+1.
- rst asserted mid-burst → out_valid 0 immediately; after release req_addr = RESET_PC.
